// File: rtl/aes128_inv_key_schedule.sv
// ============================================================================
// Module  : aes128_inv_key_schedule
// Brief   : Walks the AES-128 key schedule backwards. It takes the round-10
//           key and emits round keys 10..0 over a valid/ready interface.
//           Optional macro AES_INV_KEY_FWD_EXPAND_EN makes KEY_IN the cipher
//           key and runs the forward expansion internally before emitting.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module aes128_inv_key_schedule #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [127:0] i_key_in,
  output logic [127:0] o_out_key,
  output logic [3:0]   o_out_round,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic         o_busy,
  output logic         o_done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EMIT   = 2'd1;
`ifdef AES_INV_KEY_FWD_EXPAND_EN
  localparam logic [1:0] S_EXPAND = 2'd2;
`endif

  localparam logic [3:0] C_LAST_ROUND = 4'(NUM_ROUNDS);

  // Byte x of the forward S-box lives at element [255-x], i.e. index ~x.
  localparam logic [255:0][7:0] C_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] f_sbox(input logic [7:0] x);
    return C_SBOX[~x];
  endfunction

  function automatic logic [31:0] f_t(input logic [31:0] w);
    return {f_sbox(w[23:16]), f_sbox(w[15:8]), f_sbox(w[7:0]), f_sbox(w[31:24])};
  endfunction

  function automatic logic [7:0] f_rc(input logic [3:0] idx);
    logic [7:0] rc;
    case (idx)
      4'd0:    rc = 8'h01;
      4'd1:    rc = 8'h02;
      4'd2:    rc = 8'h04;
      4'd3:    rc = 8'h08;
      4'd4:    rc = 8'h10;
      4'd5:    rc = 8'h20;
      4'd6:    rc = 8'h40;
      4'd7:    rc = 8'h80;
      4'd8:    rc = 8'h1b;
      4'd9:    rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  logic [1:0]   r_state;
  logic [127:0] r_out_key;
  logic [3:0]   r_out_round;
  logic         r_out_valid;
  logic         r_done;

  // Inverse step: key r -> key r-1, straight from the output register.
  logic [31:0]  w_inv_w0;
  logic [31:0]  w_inv_w1;
  logic [31:0]  w_inv_w2;
  logic [31:0]  w_inv_w3;
  logic [127:0] w_inv_key;

  assign w_inv_w3  = r_out_key[31:0]  ^ r_out_key[63:32];
  assign w_inv_w2  = r_out_key[63:32] ^ r_out_key[95:64];
  assign w_inv_w1  = r_out_key[95:64] ^ r_out_key[127:96];
  assign w_inv_w0  = r_out_key[127:96] ^ f_t(w_inv_w3) ^
                     {f_rc(r_out_round - 4'd1), 24'h000000};
  assign w_inv_key = {w_inv_w0, w_inv_w1, w_inv_w2, w_inv_w3};

`ifdef AES_INV_KEY_FWD_EXPAND_EN
  logic [127:0] r_exp_key;
  logic [3:0]   r_exp_cnt;
  logic [31:0]  w_fwd_w0;
  logic [31:0]  w_fwd_w1;
  logic [31:0]  w_fwd_w2;
  logic [31:0]  w_fwd_w3;
  logic [127:0] w_fwd_key;

  assign w_fwd_w0  = r_exp_key[127:96] ^ f_t(r_exp_key[31:0]) ^
                     {f_rc(r_exp_cnt), 24'h000000};
  assign w_fwd_w1  = r_exp_key[95:64] ^ w_fwd_w0;
  assign w_fwd_w2  = r_exp_key[63:32] ^ w_fwd_w1;
  assign w_fwd_w3  = r_exp_key[31:0]  ^ w_fwd_w2;
  assign w_fwd_key = {w_fwd_w0, w_fwd_w1, w_fwd_w2, w_fwd_w3};
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_out_key   <= '0;
      r_out_round <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
`ifdef AES_INV_KEY_FWD_EXPAND_EN
      r_exp_key   <= '0;
      r_exp_cnt   <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
`ifdef AES_INV_KEY_FWD_EXPAND_EN
            r_exp_key <= i_key_in;
            r_exp_cnt <= 4'd0;
            r_state   <= S_EXPAND;
`else
            r_out_key   <= i_key_in;
            r_out_round <= C_LAST_ROUND;
            r_out_valid <= 1'b1;
            r_state     <= S_EMIT;
`endif
          end
        end
`ifdef AES_INV_KEY_FWD_EXPAND_EN
        S_EXPAND: begin
          // The last forward step lands directly in the output register.
          if (r_exp_cnt == C_LAST_ROUND - 4'd1) begin
            r_out_key   <= w_fwd_key;
            r_out_round <= C_LAST_ROUND;
            r_out_valid <= 1'b1;
            r_state     <= S_EMIT;
          end else begin
            r_exp_key <= w_fwd_key;
            r_exp_cnt <= r_exp_cnt + 4'd1;
          end
        end
`endif
        S_EMIT: begin
          if (i_out_ready) begin
            if (r_out_round != 4'd0) begin
              r_out_key   <= w_inv_key;
              r_out_round <= r_out_round - 4'd1;
            end else begin
              r_out_valid <= 1'b0;
              r_done      <= 1'b1;
              r_state     <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_out_key   = r_out_key;
  assign o_out_round = r_out_round;
  assign o_out_valid = r_out_valid;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_aes128_inv_key_schedule.sv
// Testbench for aes128_inv_key_schedule: FIPS-197 word-recurrence model with
// an S-box derived from GF(2^8) inversion; follows AES_INV_KEY_FWD_EXPAND_EN.
`default_nettype none

module tb_aes128_inv_key_schedule;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic [127:0] out_key;
  logic [3:0]   out_round;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic         done;

  int checks   = 0;
  int failures = 0;

`ifdef AES_INV_KEY_FWD_EXPAND_EN
  localparam int LAT = 11;
  localparam logic [127:0] GOLD_IN = 128'h2b7e151628aed2a6abf7158809cf4f3c;
`else
  localparam int LAT = 1;
  localparam logic [127:0] GOLD_IN = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
`endif
  localparam logic [127:0] GOLD_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] GOLD_R9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] GOLD_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] GOLD_R0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  aes128_inv_key_schedule #(.NUM_ROUNDS(10)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_key_in    (key_in),
    .o_out_key   (out_key),
    .o_out_round (out_round),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_busy      (busy),
    .o_done      (done)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0]  sb [256];
  logic [7:0]  rc_tab [11];
  logic [31:0] mw [44];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00; x = a; y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic init_model();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] t;
    logic [7:0] rc;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv; t = inv;
      for (int k = 0; k < 4; k++) begin
        t = {t[6:0], t[7]};
        s = s ^ t;
      end
      sb[x] = s ^ 8'h63;
    end
    rc = 8'h01;
    rc_tab[0] = 8'h00;
    for (int i = 1; i <= 10; i++) begin
      rc_tab[i] = rc;
      rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
    end
  endtask

  function automatic logic [31:0] subrot(input logic [31:0] w);
    return {sb[w[23:16]], sb[w[15:8]], sb[w[7:0]], sb[w[31:24]]};
  endfunction

  // Fill the 44-word schedule from whichever end KEY_IN represents.
  task automatic build_model(input logic [127:0] k);
    logic [31:0] temp;
`ifdef AES_INV_KEY_FWD_EXPAND_EN
    mw[0] = k[127:96]; mw[1] = k[95:64]; mw[2] = k[63:32]; mw[3] = k[31:0];
    for (int j = 4; j < 44; j++) begin
      temp = (j % 4 == 0) ? (subrot(mw[j-1]) ^ {rc_tab[j/4], 24'h0}) : mw[j-1];
      mw[j] = mw[j-4] ^ temp;
    end
`else
    mw[40] = k[127:96]; mw[41] = k[95:64]; mw[42] = k[63:32]; mw[43] = k[31:0];
    for (int i = 39; i >= 0; i--) begin
      temp = (i % 4 == 0) ? (subrot(mw[i+3]) ^ {rc_tab[(i+4)/4], 24'h0}) : mw[i+3];
      mw[i] = mw[i+4] ^ temp;
    end
`endif
  endtask

  function automatic logic [127:0] model_key(input int r);
    return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic pulse_start(input logic [127:0] k);
    key_in = k;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 1;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int n;
    rst_n = 1'b0; start = 1'b0; key_in = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({out_key, out_round, out_valid, busy, done} !== 135'b0) begin
      failures++;
      $display("FAIL reset_outputs got key=%h rnd=%0d v=%b b=%b d=%b exp all 0",
               out_key, out_round, out_valid, busy, done);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle got busy=%b valid=%b exp 0 0", busy, out_valid);
    end
    // Abort a schedule in progress.
    pulse_start({$urandom, $urandom, $urandom, $urandom});
    wait_valid(n);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_key, out_round, out_valid, busy, done} !== 135'b0) begin
      failures++;
      $display("FAIL reset_async got key=%h rnd=%0d v=%b b=%b d=%b exp all 0",
               out_key, out_round, out_valid, busy, done);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_abort got busy=%b done=%b valid=%b exp 0 0 0",
                 busy, done, out_valid);
      end
    end
  endtask

  task automatic test_golden();
    int n;
    int e;
    int cyc;
    build_model(GOLD_IN);
    out_ready = 1'b1;
    pulse_start(GOLD_IN);
    wait_valid(n);
    checks++;
    if (n != LAT) begin
      failures++;
      $display("FAIL golden_latency got %0d exp %0d", n, LAT);
    end
    checks++;
    if (out_key !== GOLD_R10) begin
      failures++;
      $display("FAIL golden_r10 got %h exp %h", out_key, GOLD_R10);
    end
    e = 10; cyc = 0;
    while (e >= 0 && cyc < 60) begin
      checks++;
      if (out_valid !== 1'b1 || done !== 1'b0 || out_round !== 4'(e) ||
          out_key !== model_key(e)) begin
        failures++;
        $display("FAIL golden_key r=%0d got v=%b d=%b rnd=%0d key=%h exp rnd=%0d key=%h",
                 e, out_valid, done, out_round, out_key, e, model_key(e));
      end
      if (e == 9 || e == 1 || e == 0) begin
        checks++;
        if (out_key !== (e == 9 ? GOLD_R9 : (e == 1 ? GOLD_R1 : GOLD_R0))) begin
          failures++;
          $display("FAIL golden_const r=%0d got %h", e, out_key);
        end
      end
      @(posedge clk); #1;
      e--; cyc++;
    end
    checks++;
    if (cyc != 11 || done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        out_key !== GOLD_R0) begin
      failures++;
      $display("FAIL golden_done got keys=%0d d=%b v=%b b=%b key=%h exp 11 1 0 0 %h",
               cyc, done, out_valid, busy, out_key, GOLD_R0);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL golden_done_pulse got %b exp 0", done);
    end
  endtask

  task automatic test_random_ready();
    int n;
    int e;
    int cyc;
    logic r;
    logic [127:0] prev;
    logic held;
    build_model(GOLD_IN);
    out_ready = 1'b0;
    pulse_start(GOLD_IN);
    wait_valid(n);
    e = 10; cyc = 0; held = 1'b0; prev = '0;
    while (e >= 0 && cyc < 400) begin
      checks++;
      if (out_valid !== 1'b1 || out_round !== 4'(e) || out_key !== model_key(e) ||
          (held && out_key !== prev)) begin
        failures++;
        $display("FAIL rready_key r=%0d got v=%b rnd=%0d key=%h exp key=%h held=%b",
                 e, out_valid, out_round, out_key, model_key(e), held);
      end
      r = 1'($urandom_range(0, 1));
      out_ready = r;
      prev = out_key;
      held = ~r;
      @(posedge clk); #1;
      if (r) e--;
      cyc++;
    end
    out_ready = 1'b0;
    checks++;
    if (e != -1 || done !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rready_done got left=%0d d=%b v=%b exp -1 1 0", e, done, out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_start_ignored();
    int n;
    int e;
    int cyc;
    int extra_done;
    logic [127:0] k;
    k = {$urandom, $urandom, $urandom, $urandom};
    build_model(k);
    out_ready = 1'b1;
    pulse_start(k);
    wait_valid(n);
    e = 10; cyc = 0;
    while (e >= 0 && cyc < 60) begin
      checks++;
      if (out_valid !== 1'b1 || out_round !== 4'(e) || out_key !== model_key(e)) begin
        failures++;
        $display("FAIL ignore_key r=%0d got rnd=%0d key=%h exp %h",
                 e, out_round, out_key, model_key(e));
      end
      start  = (e == 5);
      key_in = ~k;
      @(posedge clk); #1;
      start = 1'b0;
      e--; cyc++;
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL ignore_done got %b exp 1", done);
    end
    extra_done = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done === 1'b1 || out_valid === 1'b1) extra_done++;
    end
    checks++;
    if (extra_done != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ignore_single_done got extra=%0d busy=%b exp 0 0", extra_done, busy);
    end
  endtask

  task automatic test_zero_key();
    int n;
    int e;
    int cyc;
    build_model(128'h0);
    out_ready = 1'b1;
    pulse_start(128'h0);
    wait_valid(n);
    e = 10; cyc = 0;
    while (e >= 0 && cyc < 60) begin
      checks++;
      if (out_valid !== 1'b1 || out_round !== 4'(e) || out_key !== model_key(e)) begin
        failures++;
        $display("FAIL zero_key r=%0d got rnd=%0d key=%h exp %h",
                 e, out_round, out_key, model_key(e));
      end
      @(posedge clk); #1;
      e--; cyc++;
    end
    checks++;
    if (cyc != 11 || done !== 1'b1) begin
      failures++;
      $display("FAIL zero_done got keys=%0d done=%b exp 11 1", cyc, done);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int n;
    int e;
    int cyc;
    logic [127:0] k2;
    k2 = {$urandom, $urandom, $urandom, $urandom};
    build_model(GOLD_IN);
    out_ready = 1'b1;
    pulse_start(GOLD_IN);
    wait_valid(n);
    cyc = 0;
    while (!(out_valid && out_round == 4'd0) && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    // START held across the edge that produces DONE and the one after it.
    key_in = k2;
    start  = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_done_edge got d=%b b=%b v=%b exp 1 0 0", done, busy, out_valid);
    end
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_accept got busy=%b exp 1", busy);
    end
    build_model(k2);
    wait_valid(n);
    checks++;
    if (n != LAT) begin
      failures++;
      $display("FAIL b2b_latency got %0d exp %0d", n, LAT);
    end
    e = 10; cyc = 0;
    while (e >= 0 && cyc < 60) begin
      checks++;
      if (out_valid !== 1'b1 || out_round !== 4'(e) || out_key !== model_key(e)) begin
        failures++;
        $display("FAIL b2b_key r=%0d got rnd=%0d key=%h exp %h",
                 e, out_round, out_key, model_key(e));
      end
      @(posedge clk); #1;
      e--; cyc++;
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL b2b_done got %b exp 1", done);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    init_model();
    test_reset();
    test_golden();
    test_random_ready();
    test_start_ignored();
    test_zero_key();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
